// File: rtl/cache_pkg.sv
// Shared cache geometry defaults and line-controller state encoding.
package cache_pkg;

   localparam int unsigned DefSets  = 256;
   localparam int unsigned DefWays  = 2;
   localparam int unsigned DefWords = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRefill,
      StWback
   } cache_state_e;

endpackage

// File: rtl/cache_bank_ram.sv
// Single-port, byte-write-enabled RAM with registered read (read-first).
// Contents are never reset so the array maps onto block RAM.
module cache_bank_ram
   import cache_pkg::*;
#(
   parameter int unsigned Depth = DefSets * DefWords,
   parameter int unsigned AddrW = $clog2(Depth)
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic [3:0]       we_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [Depth];
   logic [31:0] rdata_q;

   // Output register only moves on an enabled access, so it holds across idle cycles.
   always_ff @(posedge clk) begin
      if (en_i) begin
         for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_data_array.sv
// Cache data array: CPU word access, line refill and victim-line writeback
// over one single-port RAM bank per way.
module cache_data_array
   import cache_pkg::*;
#(
   parameter int unsigned SETS  = DefSets,
   parameter int unsigned WAYS  = DefWays,
   parameter int unsigned WORDS = DefWords,
   localparam int unsigned IW = $clog2(SETS),
   localparam int unsigned AW = $clog2(WAYS),
   localparam int unsigned OW = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [3:0]    req_wstrb,
   input  logic [IW-1:0] req_index,
   input  logic [AW-1:0] req_way,
   input  logic [OW-1:0] req_offset,
   input  logic [31:0]   req_wdata,
   output logic [31:0]   rd_data,
   output logic          rd_valid,
   input  logic          refill_start,
   input  logic          refill_valid,
   input  logic [31:0]   refill_data,
   output logic          refill_done,
   input  logic          wb_start,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [31:0]   wb_data,
   output logic          wb_last,
   output logic          busy
);

   localparam logic [OW-1:0] LastWord = OW'(WORDS - 1);

   cache_state_e  state_q, state_d;
   logic [OW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [IW-1:0] line_idx_q, line_idx_d;
   logic [AW-1:0] line_way_q, line_way_d;
   logic [AW-1:0] rd_way_q, rd_way_d;
   logic          rd_valid_q, rd_valid_d;
   logic          wb_valid_q, wb_valid_d;
   logic          refill_done_q, refill_done_d;
   logic [31:0]   rd_hold_q;

   logic          acc_en;
   logic [3:0]    acc_we;
   logic [AW-1:0] acc_way;
   logic [IW-1:0] acc_idx;
   logic [OW-1:0] acc_off;
   logic [31:0]   acc_wdata;
   logic [31:0]   ram_rdata [WAYS];

   assign cnt_inc = cnt_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      line_idx_d    = line_idx_q;
      line_way_d    = line_way_q;
      rd_way_d      = rd_way_q;
      rd_valid_d    = 1'b0;
      wb_valid_d    = wb_valid_q;
      refill_done_d = 1'b0;
      acc_en        = 1'b0;
      acc_we        = 4'h0;
      acc_way       = req_way;
      acc_idx       = req_index;
      acc_off       = req_offset;
      acc_wdata     = req_wdata;

      unique case (state_q)
         StIdle: begin
            if (wb_start) begin
               state_d    = StWback;
               line_idx_d = req_index;
               line_way_d = req_way;
               cnt_d      = '0;
               wb_valid_d = 1'b0;
            end else if (refill_start) begin
               state_d    = StRefill;
               line_idx_d = req_index;
               line_way_d = req_way;
               cnt_d      = '0;
            end else if (req_valid) begin
               acc_en = 1'b1;
               if (req_we) begin
                  acc_we = req_wstrb;
               end else begin
                  rd_valid_d = 1'b1;
                  rd_way_d   = req_way;
               end
            end
         end

         StRefill: begin
            acc_way   = line_way_q;
            acc_idx   = line_idx_q;
            acc_off   = cnt_q;
            acc_wdata = refill_data;
            if (refill_valid) begin
               acc_en = 1'b1;
               acc_we = 4'hF;
               cnt_d  = cnt_inc;
               if (cnt_q == LastWord) begin
                  state_d       = StIdle;
                  refill_done_d = 1'b1;
               end
            end
         end

         StWback: begin
            acc_way = line_way_q;
            acc_idx = line_idx_q;
            acc_off = cnt_q;
            // First cycle fetches word 0; afterwards each handshake prefetches the next word.
            if (!wb_valid_q) begin
               acc_en     = 1'b1;
               wb_valid_d = 1'b1;
            end else if (wb_ready) begin
               if (cnt_q == LastWord) begin
                  state_d    = StIdle;
                  wb_valid_d = 1'b0;
                  cnt_d      = '0;
               end else begin
                  acc_en  = 1'b1;
                  acc_off = cnt_inc;
                  cnt_d   = cnt_inc;
               end
            end
         end

         default: state_d = StIdle;
      endcase

      // Reset wins over any access so an aborted refill writes nothing more.
      if (!resetn) begin
         acc_en = 1'b0;
      end
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      cache_bank_ram #(
         .Depth(SETS * WORDS)
      ) u_ram (
         .clk    (clk),
         .en_i   (acc_en && (acc_way == AW'(w))),
         .we_i   (acc_we),
         .addr_i ({acc_idx, acc_off}),
         .wdata_i(acc_wdata),
         .rdata_o(ram_rdata[w])
      );
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         line_idx_q    <= '0;
         line_way_q    <= '0;
         rd_way_q      <= '0;
         rd_valid_q    <= 1'b0;
         wb_valid_q    <= 1'b0;
         refill_done_q <= 1'b0;
         rd_hold_q     <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         line_idx_q    <= line_idx_d;
         line_way_q    <= line_way_d;
         rd_way_q      <= rd_way_d;
         rd_valid_q    <= rd_valid_d;
         wb_valid_q    <= wb_valid_d;
         refill_done_q <= refill_done_d;
         rd_hold_q     <= rd_data;
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rd_valid_q ? ram_rdata[rd_way_q] : rd_hold_q;
   assign wb_valid    = wb_valid_q;
   assign wb_data     = wb_valid_q ? ram_rdata[line_way_q] : '0;
   assign wb_last     = wb_valid_q && (cnt_q == LastWord);
   assign refill_done = refill_done_q;

endmodule

// File: doc/cache_data_array.md
CACHE_DATA_ARRAY -- requirements
Module: cache_data_array

Interface
REQ-001 SHALL have parameter SETS, default 256, number of sets (power of 2).
REQ-002 SHALL have parameter WAYS, default 2, associativity (power of 2).
REQ-003 SHALL have parameter WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-004 SHALL derive IW=$clog2(SETS), AW=$clog2(WAYS), OW=$clog2(WORDS) as localparams.
REQ-005 SHALL have ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  CPU access request
- req_ready  out  1  CPU access accepted (high only in IDLE)
- req_we  in  1  1=write, 0=read
- req_wstrb  in  4  byte enables for writes
- req_index  in  IW  set
- req_way  in  AW  way
- req_offset  in  OW  word in line
- req_wdata  in  32  write data
- rd_data  out  32  read data
- rd_valid  out  1  rd_data valid pulse
- refill_start  in  1  begin line refill at req_index/req_way
- refill_valid  in  1  refill word present
- refill_data  in  32  refill word
- refill_done  out  1  one-cycle pulse after last refill word written
- wb_start  in  1  begin victim-line drain at req_index/req_way
- wb_valid  out  1  wb_data valid
- wb_ready  in  1  downstream accepts wb_data
- wb_data  out  32  victim word
- wb_last  out  1  marks final victim word
- busy  out  1  state != IDLE

Function
REQ-006 SHALL implement FSM states IDLE, REFILL, WBACK; state, counters and outputs change only on rising clk.
REQ-007 SHALL, in IDLE, give priority wb_start > refill_start > req_valid; lower-priority inputs that cycle are ignored, not queued.
REQ-008 SHALL latch req_index/req_way as the line target on wb_start or refill_start and zero the word counter.
REQ-009 SHALL perform a CPU write in IDLE when req_valid&req_we: only bytes with req_wstrb[i]=1 updated, same cycle edge.
REQ-010 SHALL perform a CPU read in IDLE when req_valid&!req_we: rd_data and rd_valid=1 on the next cycle (latency 1); rd_valid=0 otherwise; rd_data holds its last value when rd_valid=0.
REQ-011 SHALL return old data for a read and write to the same word in the same cycle (not possible via one port; write-then-read next cycle SHALL return the new data).
REQ-012 SHALL in REFILL write refill_data to word counter on each refill_valid cycle (all 4 bytes), increment counter; after word WORDS-1 return to IDLE with refill_done=1 that cycle (counter wraps to 0).
REQ-013 SHALL in REFILL hold state indefinitely while refill_valid=0.
REQ-014 SHALL in WBACK stream words 0..WORDS-1 of the latched line with valid/ready: wb_data/wb_last stable while wb_valid&!wb_ready; word advances only on wb_valid&wb_ready.
REQ-015 SHALL present the first WBACK word with wb_valid=1 no later than 2 cycles after wb_start and sustain one word per cycle while wb_ready=1.
REQ-016 SHALL assert wb_last with the word at offset WORDS-1 and enter IDLE on its handshake.
REQ-017 SHALL keep req_ready=0, ignore req_valid, refill_start and wb_start while busy=1.

Reset
REQ-018 SHALL, on resetn=0 at a clk edge, including mid-REFILL/WBACK, force IDLE, counters 0, rd_valid=0, rd_data=0, wb_valid=0, wb_last=0, wb_data=0, refill_done=0, busy=0; aborted lines left partially written.
REQ-019 SHALL NOT clear storage contents on reset (contents undefined until written), so arrays map to block RAM.

Structure
REQ-020 SHALL place default SETS/WAYS/WORDS and the FSM state encoding in shared package cache_pkg, also used by tag and control blocks.
REQ-021 SHALL instantiate one sub-module cache_bank_ram per way: single-port, byte-write-enabled, registered-read RAM of SETS*WORDS words.

Verification
REQ-022 SHALL cover: write 0xDEADBEEF set 5 way 1 word 2, read same -> rd_valid next cycle, rd_data=0xDEADBEEF.
REQ-023 SHALL cover: write 0x11223344 then wstrb=4'b0010 data 0xAABBCCDD same word, read -> 0x1122CC44.
REQ-024 SHALL cover: refill set 9 way 0 with words 0xA0..0xA3, refill_valid gapped every other cycle -> refill_done after 4th word, reads return 0xA0..0xA3.
REQ-025 SHALL cover: WBACK of that line with wb_ready low cycles 2 and 4 -> wb_data sequence 0xA0,0xA1,0xA2,0xA3 exactly once each, held while stalled, wb_last only on 0xA3.
REQ-026 SHALL cover: wb_start and refill_start same cycle -> WBACK entered, refill ignored; req_valid during busy -> req_ready=0, no write.
REQ-027 SHALL cover: resetn low after 2nd refill word -> next cycle IDLE, busy=0, refill_done never pulses, words 0..1 written, 2..3 unchanged.
